// File: rtl/pipe_ctrl_regs.sv
// pipe_ctrl_regs: F/D, D/E, E/M and M/W pipeline registers for the RV32I
// 5-stage core. Carries instruction word, PC, valid bit and decoded
// write-back controls. Bubbles are NOP_INSTR with valid=0.
// Optional retire/bubble counters are built only when PIPE_RETIRE_CNT_EN
// is defined.
module pipe_ctrl_regs #(
  parameter int               XLEN      = 32,
  parameter logic [XLEN-1:0]  NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] instr_F,
  input  logic [XLEN-1:0] pc_F,
  input  logic            stall_D,
  input  logic            flush_D,
  input  logic            flush_E,
  output logic [XLEN-1:0] IR_D,
  output logic [XLEN-1:0] IR_E,
  output logic [XLEN-1:0] IR_M,
  output logic [XLEN-1:0] IR_W,
  output logic [XLEN-1:0] pc_D,
  output logic [XLEN-1:0] pc_E,
  output logic [XLEN-1:0] pc_M,
  output logic [XLEN-1:0] pc_W,
  output logic            valid_D,
  output logic            valid_E,
  output logic            valid_M,
  output logic            valid_W,
  output logic [1:0]      wb_sel_E,
  output logic [1:0]      wb_sel_M,
  output logic [1:0]      wb_sel_W,
  output logic            regwrite_E,
  output logic            regwrite_M,
  output logic            regwrite_W
`ifdef PIPE_RETIRE_CNT_EN
  ,
  output logic [31:0]     retired_cnt,
  output logic [31:0]     bubble_cnt
`endif
);

  logic [6:0] opcode_D;
  logic       dec_regwrite;
  logic [1:0] dec_wb_sel;

  // Decode write-back controls of the D-stage instruction for the D/E load.
  always_comb begin
    dec_regwrite = 1'b0;
    dec_wb_sel   = 2'b00;
    opcode_D     = IR_D[6:0];
    case (opcode_D)
      7'd51, 7'd19, 7'd55, 7'd23: dec_regwrite = valid_D;
      7'd3: begin
        dec_regwrite = valid_D;
        dec_wb_sel   = 2'b10;
      end
      7'd111, 7'd103: begin
        dec_regwrite = valid_D;
        dec_wb_sel   = 2'b01;
      end
      default: begin
        dec_regwrite = 1'b0;
        dec_wb_sel   = 2'b00;
      end
    endcase
  end

  // F/D register: flush beats stall; PC is kept on a flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      IR_D    <= NOP_INSTR;
      pc_D    <= '0;
      valid_D <= 1'b0;
    end else if (flush_D) begin
      IR_D    <= NOP_INSTR;
      valid_D <= 1'b0;
    end else if (!stall_D) begin
      IR_D    <= instr_F;
      pc_D    <= pc_F;
      valid_D <= 1'b1;
    end
  end

  // D/E register: bubble on flush_E, otherwise take D and its decode.
  // During a load-use stall flush_E is also raised, so D holding never
  // duplicates an instruction into E.
  always_ff @(posedge clk) begin
    if (rst) begin
      IR_E       <= NOP_INSTR;
      pc_E       <= '0;
      valid_E    <= 1'b0;
      wb_sel_E   <= 2'b00;
      regwrite_E <= 1'b0;
    end else if (flush_E) begin
      IR_E       <= NOP_INSTR;
      valid_E    <= 1'b0;
      wb_sel_E   <= 2'b00;
      regwrite_E <= 1'b0;
    end else begin
      IR_E       <= IR_D;
      pc_E       <= pc_D;
      valid_E    <= valid_D;
      wb_sel_E   <= dec_wb_sel;
      regwrite_E <= dec_regwrite;
    end
  end

  // E/M and M/W registers: unconditional shift, controls travel along.
  always_ff @(posedge clk) begin
    if (rst) begin
      IR_M       <= NOP_INSTR;
      pc_M       <= '0;
      valid_M    <= 1'b0;
      wb_sel_M   <= 2'b00;
      regwrite_M <= 1'b0;
      IR_W       <= NOP_INSTR;
      pc_W       <= '0;
      valid_W    <= 1'b0;
      wb_sel_W   <= 2'b00;
      regwrite_W <= 1'b0;
    end else begin
      IR_M       <= IR_E;
      pc_M       <= pc_E;
      valid_M    <= valid_E;
      wb_sel_M   <= wb_sel_E;
      regwrite_M <= regwrite_E;
      IR_W       <= IR_M;
      pc_W       <= pc_M;
      valid_W    <= valid_M;
      wb_sel_W   <= wb_sel_M;
      regwrite_W <= regwrite_M;
    end
  end

`ifdef PIPE_RETIRE_CNT_EN
  // Count retired instructions and bubbles leaving W; both wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_cnt <= 32'd0;
      bubble_cnt  <= 32'd0;
    end else if (valid_W) begin
      retired_cnt <= retired_cnt + 32'd1;
    end else begin
      bubble_cnt  <= bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl_regs.sv
// Testbench for pipe_ctrl_regs: directed scenarios plus randomized
// stimulus, all checked against a record-based pipeline model.
module tb_pipe_ctrl_regs;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_F, pc_F;
  logic        stall_D, flush_D, flush_E;
  logic [31:0] IR_D, IR_E, IR_M, IR_W, pc_D, pc_E, pc_M, pc_W;
  logic        valid_D, valid_E, valid_M, valid_W;
  logic [1:0]  wb_sel_E, wb_sel_M, wb_sel_W;
  logic        regwrite_E, regwrite_M, regwrite_W;
`ifdef PIPE_RETIRE_CNT_EN
  logic [31:0] retired_cnt, bubble_cnt;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipe_ctrl_regs dut (
    .clk(clk), .rst(rst), .instr_F(instr_F), .pc_F(pc_F),
    .stall_D(stall_D), .flush_D(flush_D), .flush_E(flush_E),
    .IR_D(IR_D), .IR_E(IR_E), .IR_M(IR_M), .IR_W(IR_W),
    .pc_D(pc_D), .pc_E(pc_E), .pc_M(pc_M), .pc_W(pc_W),
    .valid_D(valid_D), .valid_E(valid_E), .valid_M(valid_M), .valid_W(valid_W),
    .wb_sel_E(wb_sel_E), .wb_sel_M(wb_sel_M), .wb_sel_W(wb_sel_W),
    .regwrite_E(regwrite_E), .regwrite_M(regwrite_M), .regwrite_W(regwrite_W)
`ifdef PIPE_RETIRE_CNT_EN
    , .retired_cnt(retired_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  // Model: one record per stage, index 0=D 1=E 2=M 3=W.
  typedef struct {
    logic [31:0] ir;
    logic [31:0] pc;
    logic        v;
    logic [1:0]  wb;
    logic        rw;
  } stage_t;

  stage_t st[4];
  logic [31:0] m_ret, m_bub;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic writes_rf(input logic [31:0] ir);
    int op = int'(ir[6:0]);
    return (op == 51 || op == 19 || op == 3 || op == 55 ||
            op == 23 || op == 111 || op == 103);
  endfunction

  function automatic logic [1:0] wb_source(input logic [31:0] ir);
    int op = int'(ir[6:0]);
    if (op == 3) return 2'b10;
    if (op == 111 || op == 103) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_edge();
    stage_t nx[4];
    if (rst) begin
      for (int i = 0; i < 4; i++) nx[i] = '{NOP, 32'd0, 1'b0, 2'b00, 1'b0};
      m_ret = 0;
      m_bub = 0;
    end else begin
      if (st[3].v) m_ret = m_ret + 1; else m_bub = m_bub + 1;
      nx[3] = st[2];
      nx[2] = st[1];
      if (flush_E) nx[1] = '{NOP, st[1].pc, 1'b0, 2'b00, 1'b0};
      else nx[1] = '{st[0].ir, st[0].pc, st[0].v, wb_source(st[0].ir),
                     writes_rf(st[0].ir) && st[0].v};
      if (flush_D)      nx[0] = '{NOP, st[0].pc, 1'b0, 2'b00, 1'b0};
      else if (stall_D) nx[0] = st[0];
      else              nx[0] = '{instr_F, pc_F, 1'b1, 2'b00, 1'b0};
    end
    st = nx;
  endtask

  task automatic compare_all();
    logic [31:0] ir[4], pc[4];
    logic        v[4];
    logic [1:0]  wb[4];
    logic        rw[4];
    ir = '{IR_D, IR_E, IR_M, IR_W};
    pc = '{pc_D, pc_E, pc_M, pc_W};
    v  = '{valid_D, valid_E, valid_M, valid_W};
    wb = '{2'b00, wb_sel_E, wb_sel_M, wb_sel_W};
    rw = '{1'b0, regwrite_E, regwrite_M, regwrite_W};
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ir%0d", i), ir[i], st[i].ir);
      check($sformatf("valid%0d", i), {31'd0, v[i]}, {31'd0, st[i].v});
      // PC of a never-loaded or flushed slot is still defined (0 or kept).
      check($sformatf("pc%0d", i), pc[i], st[i].pc);
      if (i > 0) begin
        check($sformatf("wb_sel%0d", i), {30'd0, wb[i]}, {30'd0, st[i].wb});
        check($sformatf("regwrite%0d", i), {31'd0, rw[i]}, {31'd0, st[i].rw});
      end
    end
`ifdef PIPE_RETIRE_CNT_EN
    check("retired_cnt", retired_cnt, m_ret);
    check("bubble_cnt", bubble_cnt, m_bub);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic drive(input logic [31:0] ins, input logic s, input logic fd, input logic fe);
    instr_F = ins;
    pc_F    = pc_F + 32'd4;
    stall_D = s;
    flush_D = fd;
    flush_E = fe;
  endtask

  initial begin
    logic [31:0] r;
    int sel;
    int opt[10] = '{51, 19, 3, 55, 23, 111, 103, 35, 99, 0};

    for (int i = 0; i < 4; i++) st[i] = '{NOP, 32'd0, 1'b0, 2'b00, 1'b0};
    m_ret = 0; m_bub = 0;
    rst = 1'b1; instr_F = 32'h0050_0093; pc_F = 32'h100;
    stall_D = 0; flush_D = 0; flush_E = 0;

    // Reset held 2 cycles with a real instruction on fetch.
    step(); step();
    check("rst_IR_W", IR_W, NOP);
    check("rst_valid_D", {31'd0, valid_D}, 32'd0);
    check("rst_regwrite_W", {31'd0, regwrite_W}, 32'd0);

    rst = 1'b0;
    step();
    check("lat_IR_D", IR_D, 32'h0050_0093);
    drive(NOP, 0, 0, 0);
    step(); step(); step();
    check("lat_IR_W", IR_W, 32'h0050_0093);
    check("lat_regwrite_W", {31'd0, regwrite_W}, 32'd1);
    check("lat_wb_sel_W", {30'd0, wb_sel_W}, 32'd0);

    // Load-use: lw then add, stall D / bubble E for one cycle.
    drive(32'h0000_A283, 0, 0, 0); step();
    drive(32'h0022_8333, 0, 0, 0); step();
    drive(NOP, 1, 0, 1);
    check("lu_wb_sel_E", {30'd0, wb_sel_E}, 32'd2);
    step();
    check("lu_hold_D", IR_D, 32'h0022_8333);
    check("lu_bubble_E", {31'd0, valid_E}, 32'd0);
    drive(NOP, 0, 0, 0); step();
    check("lu_add_E", IR_E, 32'h0022_8333);
    check("lu_lw_W", IR_W, 32'h0000_A283);
    step();
    check("lu_bubble_W", {31'd0, valid_W}, 32'd0);

    // Taken branch: two bubbles; the E instruction still retires.
    drive(32'h0010_0113, 0, 0, 0); step();
    drive(32'h0020_0193, 0, 0, 0); step();
    drive(32'h0030_0213, 0, 1, 1); step();
    check("br_IR_D", IR_D, NOP);
    check("br_IR_E", IR_E, NOP);
    check("br_valid_E", {31'd0, valid_E}, 32'd0);
    drive(NOP, 0, 0, 0); step();
    check("br_old_E_W", IR_W, 32'h0010_0113);

    // Store and branch never write the register file.
    drive(32'h0050_A023, 0, 0, 0); step();
    drive(32'h0020_8463, 0, 0, 0); step();
    drive(NOP, 0, 0, 0); step();
    check("sw_regwrite_M", {31'd0, regwrite_M}, 32'd0);
    step();
    check("beq_regwrite_M", {31'd0, regwrite_M}, 32'd0);

    // jal decode, then stall with flush_D: flush wins.
    drive(32'h0080_00EF, 0, 0, 0); step();
    drive(NOP, 0, 0, 0); step();
    check("jal_wb_sel_E", {30'd0, wb_sel_E}, 32'd1);
    check("jal_regwrite_E", {31'd0, regwrite_E}, 32'd1);
    drive(32'h0040_0293, 1, 1, 0); step();
    check("sf_valid_D", {31'd0, valid_D}, 32'd0);
    check("sf_IR_D", IR_D, NOP);

    // Randomized traffic with occasional mid-run reset.
    for (int n = 0; n < 400; n++) begin
      r = $urandom();
      sel = int'($urandom_range(0, 9));
      instr_F = (sel == 9) ? r : {r[31:7], 7'(opt[sel])};
      pc_F    = $urandom();
      stall_D = ($urandom_range(0, 5) == 0);
      flush_D = ($urandom_range(0, 7) == 0);
      flush_E = ($urandom_range(0, 6) == 0) || stall_D;
      rst     = ($urandom_range(0, 60) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl_regs.md
Name: pipe_ctrl_regs

Overview:
- Owns the F/D, D/E, E/M and M/W instruction pipeline registers of the RV32I 5-stage core.
- Consumes the stall and flush controls produced by the hazard logic.
- Produces the per-stage instruction words and decoded write-back controls that the hazard logic and the datapath consume: IR_D..IR_W, wb_sel_E, regwrite_M, regwrite_W.
- Also carries the PC alongside each instruction and marks bubbles with per-stage valid bits.

Parameters:
- XLEN, 32, width of PC and instruction words.
- NOP_INSTR, 32'h00000013, encoding inserted as a bubble (addi x0,x0,0).

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- instr_F  in  XLEN  instruction fetched this cycle.
- pc_F  in  XLEN  PC of instr_F.
- stall_D  in  1  hold F/D register.
- flush_D  in  1  replace F/D contents with a bubble.
- flush_E  in  1  replace D/E contents with a bubble.
- IR_D, IR_E, IR_M, IR_W  out  XLEN  instruction word in each stage.
- pc_D, pc_E, pc_M, pc_W  out  XLEN  PC in each stage.
- valid_D, valid_E, valid_M, valid_W  out  1  stage holds a real instruction, not a bubble.
- wb_sel_E, wb_sel_M, wb_sel_W  out  2  write-back source per stage.
- regwrite_E, regwrite_M, regwrite_W  out  1  stage instruction writes the register file.

Behaviour:
- Reset, applied on any edge where rst=1 including mid-operation:
  - all IR_* = NOP_INSTR, all pc_* = 0, all valid_* = 0;
  - all wb_sel_* = 2'b00, all regwrite_* = 0.
- F/D register, priority flush_D > stall_D > load:
  - flush_D=1: IR_D=NOP_INSTR, valid_D=0, pc_D unchanged;
  - else stall_D=1: hold IR_D, pc_D, valid_D;
  - else: IR_D=instr_F, pc_D=pc_F, valid_D=1.
- D/E register:
  - flush_E=1: IR_E=NOP_INSTR, valid_E=0, regwrite_E=0, wb_sel_E=00;
  - else: load IR_D, pc_D, valid_D and the decode of IR_D.
- E/M and M/W registers: always advance; there is no stall or flush for these stages.
- Decode, applied on the D/E load from IR_D opcode bits [6:0]:
  - regwrite=1 for opcodes 51, 19, 3, 55, 23, 111, 103;
  - regwrite=0 for 35, 99 and any other opcode;
  - regwrite is forced to 0 when valid_D=0.
  - wb_sel: 2'b10 for load (3); 2'b01 for JAL/JALR (111/103); 2'b00 otherwise. 2'b11 is never generated.
  - wb_sel[1]=1 identifies a load in E for load-use detection.
- Controls travel with their instruction: wb_sel_M/W and regwrite_M/W are pure one-cycle delays of the E copies.
- Latency: an unstalled instruction appears in D one cycle after it is presented on instr_F, then E, M and W on each following cycle (W at cycle 4).
- Simultaneous events:
  - Load-use (stall_D=1, flush_E=1): D holds, E gets a bubble, the E→M→W shift continues.
  - Taken branch (flush_D=1, flush_E=1): two bubbles are inserted.
  - stall_D with flush_D: flush wins.
- instr_F is not sampled while stall_D=1. The fetch side is responsible for holding or re-presenting that instruction.

Optional Feature:
- Macro PIPE_RETIRE_CNT_EN.
- Defined:
  - adds output retired_cnt (32 bits);
  - resets to 0 and increments by 1 on each edge where valid_W=1;
  - wraps 32'hFFFFFFFF → 0;
  - also adds output bubble_cnt (32 bits), which increments when valid_W=0 and rst=0, with the same wrap rule.
- Undefined: neither port nor any counter logic exists.

Test Plan:
- Reset: hold rst=1 for 2 cycles while instr_F=32'h00500093 → all IR_*=32'h00000013, all valid_*=0, regwrite_*=0, wb_sel_*=00. Release rst → IR_D=32'h00500093 one cycle later, reaching IR_W 3 cycles after that with regwrite_W=1, wb_sel_W=00.
- Load-use: lw x5,0(x1) (32'h0000A283) then add x6,x5,x2 (32'h00228333), assert stall_D=1 and flush_E=1 for one cycle while add is in D and lw in E:
  - add stays in D for 2 cycles;
  - a bubble (valid=0) sits between lw and add in M/W;
  - wb_sel_E=10 during the stall cycle.
- Branch: assert flush_D=1 and flush_E=1 for one cycle → IR_D and IR_E both NOP_INSTR next cycle with valid=0; the previously E-stage instruction still reaches W.
- Store/branch decode: sw (32'h0050A023) and beq (32'h00208463) → regwrite_M=0 as each passes through M.
- jal x1,8 (32'h008000EF) → wb_sel_E=01, regwrite_E=1. stall_D=1 together with flush_D=1 → bubble in D (flush priority).
- With PIPE_RETIRE_CNT_EN defined: 10 unstalled instructions plus 2 flush bubbles → retired_cnt=10, bubble_cnt counts the 2 flush bubbles plus the post-reset drain bubbles. Preload the counter to 32'hFFFFFFFF and retire one instruction → 0.
